mem_access_unit: RTL

- MEM-stage load/store engine; the consumer end of the EX-stage memory outputs (ALU result address, store data, MemWrite, MemtoReg, MemReadType).
- Converts one EX memory request into a transaction on the SRAM-like data bus: request/addr_ok, then data_ok.
- Freezes the pipeline while the transaction is outstanding, returns aligned and extended load data, and flags address exceptions.

---
 rtl/mem_access_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns one pipeline memory request into an SRAM-like bus transaction.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        MemWrite_i,
    input  logic        MemtoReg_i,
    input  logic [2:0]  MemReadType_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        stall_o,
    output logic [2:0]  exception,
    output logic [31:0] badvaddr_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic        wr_reg, sign_reg, flushed_reg;
    logic [1:0]  size_reg;
    logic [31:0] addr_reg, wdata_reg, rdata_reg;

    logic        accept, misaligned, tmo_hit, load_capture;
    logic [1:0]  in_size;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data, in_wdata;
    logic        stall_comb;
    logic [2:0]  exc_comb;
    logic [31:0] bad_comb;

    assign accept     = (state_reg == IDLE) & valid_i & (MemWrite_i | MemtoReg_i) & ~flush_i;
    assign in_size    = (MemReadType_i[1:0] == 2'b11) ? 2'b10 : MemReadType_i[1:0];
    assign misaligned = ((in_size == 2'b01) & addr_i[0]) | ((in_size == 2'b10) & (|addr_i[1:0]));

    always_comb begin
        case (in_size)
            2'b00:   in_wdata = {4{wdata_i[7:0]}};
            2'b01:   in_wdata = {2{wdata_i[15:0]}};
            default: in_wdata = wdata_i;
        endcase
    end

    always_comb begin
        case (addr_reg[1:0])
            2'b00:   byte_lane = data_rdata[7:0];
            2'b01:   byte_lane = data_rdata[15:8];
            2'b10:   byte_lane = data_rdata[23:16];
            default: byte_lane = data_rdata[31:24];
        endcase
        half_lane = addr_reg[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (size_reg)
            2'b00:   load_data = {{24{sign_reg & byte_lane[7]}}, byte_lane};
            2'b01:   load_data = {{16{sign_reg & half_lane[15]}}, half_lane};
            default: load_data = data_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_reg <= '0;
        else if (accept && !misaligned)
            cnt_reg <= '0;
        else if (state_reg == REQ || state_reg == WAIT)
            cnt_reg <= cnt_reg + 32'd1;
    end

    assign tmo_hit = (state_reg == REQ || state_reg == WAIT) && (cnt_reg == TMO_LAST);
`else
    // No watchdog in this build: never fires for any legal limit.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_next   = state_reg;
        data_req     = 1'b0;
        done_o       = 1'b0;
        stall_comb   = 1'b0;
        exc_comb     = 3'b000;
        bad_comb     = '0;
        load_capture = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        exc_comb = MemWrite_i ? 3'b101 : 3'b100;
                        bad_comb = addr_i;
                    end else begin
                        stall_comb = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                stall_comb = 1'b1;
                if (flush_i) begin
                    state_next = IDLE;
                end else begin
                    data_req = 1'b1;
                    if (data_addr_ok) begin
                        state_next   = data_data_ok ? RESP : WAIT;
                        load_capture = data_data_ok & ~wr_reg;
                    end else if (tmo_hit) begin
                        stall_comb = 1'b0;
                        exc_comb   = 3'b110;
                        bad_comb   = addr_reg;
                        state_next = IDLE;
                    end
                end
            end
            WAIT: begin
                stall_comb = 1'b1;
                if (data_data_ok) begin
                    // A flushed transaction drains silently straight back to IDLE.
                    if (flushed_reg || flush_i) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = RESP;
                        load_capture = ~wr_reg;
                    end
                end else if (tmo_hit) begin
                    stall_comb = 1'b0;
                    exc_comb   = 3'b110;
                    bad_comb   = addr_reg;
                    state_next = IDLE;
                end
            end
            default: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Input-driven outputs are held quiet while reset is asserted.
    assign stall_o    = rst ? 1'b0 : stall_comb;
    assign exception  = rst ? 3'b000 : exc_comb;
    assign badvaddr_o = rst ? 32'd0 : bad_comb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            wr_reg      <= 1'b0;
            sign_reg    <= 1'b0;
            size_reg    <= 2'b00;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            flushed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept && !misaligned) begin
                wr_reg      <= MemWrite_i;
                sign_reg    <= MemReadType_i[2];
                size_reg    <= in_size;
                addr_reg    <= addr_i;
                wdata_reg   <= in_wdata;
                flushed_reg <= 1'b0;
            end else if (state_reg == WAIT && flush_i) begin
                flushed_reg <= 1'b1;
            end
            if (load_capture)
                rdata_reg <= load_data;
        end
    end

    assign data_wr    = wr_reg;
    assign data_size  = size_reg;
    assign data_addr  = addr_reg;
    assign data_wdata = wdata_reg;
    assign rdata_o    = rdata_reg;
endmodule
